// File: rtl/alu_pipe_if.sv
// Opcode constants and the issue/writeback handshake interface for alu_pipe.
// The "slave" modport is the execution unit; "master" is the issue/writeback side.
package alu_pipe_pkg;
    localparam logic [4:0] ALU_ADDQ   = 5'h00;
    localparam logic [4:0] ALU_SUBQ   = 5'h01;
    localparam logic [4:0] ALU_AND    = 5'h02;
    localparam logic [4:0] ALU_BIC    = 5'h03;
    localparam logic [4:0] ALU_BIS    = 5'h04;
    localparam logic [4:0] ALU_ORNOT  = 5'h05;
    localparam logic [4:0] ALU_XOR    = 5'h06;
    localparam logic [4:0] ALU_EQV    = 5'h07;
    localparam logic [4:0] ALU_SRL    = 5'h08;
    localparam logic [4:0] ALU_SLL    = 5'h09;
    localparam logic [4:0] ALU_SRA    = 5'h0a;
    localparam logic [4:0] ALU_MULQ   = 5'h0b;
    localparam logic [4:0] ALU_CMPEQ  = 5'h0c;
    localparam logic [4:0] ALU_CMPLT  = 5'h0d;
    localparam logic [4:0] ALU_CMPLE  = 5'h0e;
    localparam logic [4:0] ALU_CMPULT = 5'h0f;
    localparam logic [4:0] ALU_CMPULE = 5'h10;
endpackage

interface alu_pipe_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_opa;
    logic [WIDTH-1:0] in_opb;
    logic [4:0]       in_func;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_opa, in_opb, in_func, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_opa, in_opb, in_func, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined integer execution unit: one-cycle registered simple path plus a MUL_STAGES-deep multiplier.
// The multiplier is built only when ALU_PIPE_MUL_EN is defined; otherwise MULQ is an illegal op.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int MUL_STAGES = 4,
    parameter int TAG_W      = 6
) (
    input logic      clock,
    input logic      reset,
    alu_pipe_if.slave bus
);

    localparam int SH_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ILLEGAL = WIDTH'(64'hdeadbeefbaadbeef);

    logic             accept;
    logic             is_mul;
    logic             mul_last;
    logic             mul_stall;
    logic [WIDTH-1:0] mul_res;
    logic [TAG_W-1:0] mul_tag;

    logic             s_valid;
    logic [WIDTH-1:0] s_result;
    logic [TAG_W-1:0] s_tag;

    function automatic logic [WIDTH-1:0] alu_simple(
        input logic [4:0]       f,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [SH_W-1:0]         sh;
        logic [WIDTH-1:0]        r;
        sa = a;
        sb = b;
        sh = b[SH_W-1:0];
        r  = '0;
        case (f)
            ALU_ADDQ:   r = a + b;
            ALU_SUBQ:   r = a - b;
            ALU_AND:    r = a & b;
            ALU_BIC:    r = a & ~b;
            ALU_BIS:    r = a | b;
            ALU_ORNOT:  r = a | ~b;
            ALU_XOR:    r = a ^ b;
            ALU_EQV:    r = ~(a ^ b);
            ALU_SRL:    r = a >> sh;
            ALU_SLL:    r = a << sh;
            ALU_SRA:    r = sa >>> sh;
            ALU_CMPEQ:  r[0] = (a == b);
            ALU_CMPLT:  r[0] = (sa < sb);
            ALU_CMPLE:  r[0] = (sa <= sb);
            ALU_CMPULT: r[0] = (a < b);
            ALU_CMPULE: r[0] = (a <= b);
            default:    r = ILLEGAL;
        endcase
        return r;
    endfunction

`ifdef ALU_PIPE_MUL_EN
    localparam int CHUNK = WIDTH / MUL_STAGES;

    logic [MUL_STAGES-1:0] m_valid;
    logic [WIDTH-1:0]      m_acc [MUL_STAGES];
    logic [WIDTH-1:0]      m_opa [MUL_STAGES];
    logic [WIDTH-1:0]      m_opb [MUL_STAGES];
    logic [TAG_W-1:0]      m_tag [MUL_STAGES];

    // Partial product of a with the k-th CHUNK-bit slice of b, aligned to that slice.
    function automatic logic [WIDTH-1:0] part_prod(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input int               k
    );
        logic [CHUNK-1:0] c;
        c = b[k*CHUNK +: CHUNK];
        return (a * WIDTH'(c)) << (k*CHUNK);
    endfunction

    assign is_mul   = (bus.in_func == ALU_MULQ);
    assign mul_last = m_valid[MUL_STAGES-1];
    assign mul_res  = m_acc[MUL_STAGES-1];
    assign mul_tag  = m_tag[MUL_STAGES-1];

    // Multiplier stage valids: the whole pipe freezes only when its last stage is blocked.
    always_ff @(posedge clock) begin
        if (!reset) begin
            m_valid <= '0;
        end else if (!mul_stall) begin
            m_valid[0] <= accept && is_mul;
            for (int k = 1; k < MUL_STAGES; k++) begin
                m_valid[k] <= m_valid[k-1];
            end
        end
    end

    // stage 0 takes slice 0 from the issue port; stage k adds slice k of its carried opb
    always_ff @(posedge clock) begin
        if (!mul_stall) begin
            m_acc[0] <= part_prod(bus.in_opa, bus.in_opb, 0);
            m_opa[0] <= bus.in_opa;
            m_opb[0] <= bus.in_opb;
            m_tag[0] <= bus.in_tag;
            for (int k = 1; k < MUL_STAGES; k++) begin
                m_acc[k] <= m_acc[k-1] + part_prod(m_opa[k-1], m_opb[k-1], k);
                m_opa[k] <= m_opa[k-1];
                m_opb[k] <= m_opb[k-1];
                m_tag[k] <= m_tag[k-1];
            end
        end
    end
`else
    logic [MUL_STAGES-1:0] m_valid;

    assign m_valid  = '0;
    assign is_mul   = 1'b0;
    assign mul_last = |m_valid;
    assign mul_res  = '0;
    assign mul_tag  = '0;
`endif

    assign mul_stall    = mul_last && !bus.out_ready;
    assign bus.in_ready = reset && !mul_stall && (!s_valid || (bus.out_ready && !mul_last));
    assign accept       = bus.in_valid && bus.in_ready;

    // Simple result register: reloads on accept, drains when it wins the output port.
    always_ff @(posedge clock) begin
        if (!reset) begin
            s_valid  <= 1'b0;
            s_result <= '0;
            s_tag    <= '0;
        end else if (accept && !is_mul) begin
            s_valid  <= 1'b1;
            s_result <= alu_simple(bus.in_func, bus.in_opa, bus.in_opb);
            s_tag    <= bus.in_tag;
        end else if (bus.out_ready && !mul_last) begin
            s_valid  <= 1'b0;
        end
    end

    // Output select: a finished multiply always beats the simple register.
    assign bus.out_valid  = mul_last || s_valid;
    assign bus.out_result = mul_last ? mul_res : s_result;
    assign bus.out_tag    = mul_last ? mul_tag : s_tag;

endmodule
